// File: rtl/pes_piso_pkg.sv
// Shared types, defaults and sizing helpers for the PISO transmitter.
// The PARITY state is used only when PES_PISO_PARITY_EN is defined.
package pes_piso_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   localparam int unsigned DATA_W_DEF = 4;

   // Counter width able to hold 0..n (one spare bit so the count can reach n).
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/pes_bit_timer.sv
// Bit-period divider: produces a one-cycle tick in the last cycle of every
// BIT_DIV-cycle bit period; restarts from zero when a frame starts.
module pes_bit_timer
   import pes_piso_pkg::*;
#(
   parameter int unsigned BIT_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic bit_tick_o
);

   localparam int unsigned DIV_W = cnt_w(BIT_DIV);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

   assign bit_tick_o = en_i && (div_cnt_q == DIV_W'(BIT_DIV - 1));

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (clear_i) begin
         div_cnt_d = '0;
      end else if (en_i) begin
         div_cnt_d = bit_tick_o ? '0 : div_cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/pes_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready intake and frame strobe.
// Define PES_PISO_PARITY_EN to append an even-parity bit to every frame.
module pes_piso_tx
   import pes_piso_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned BIT_DIV   = 1,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic [DATA_W-1:0] par_data,
   input  logic              par_valid,
   output logic              par_ready,
   output logic              ser_out,
   output logic              ser_en,
   output logic              busy,
   output logic              done
);

   localparam int unsigned BC_W = cnt_w(DATA_W);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic              bit_tick;
   logic              start;
   logic              last_bit;

`ifdef PES_PISO_PARITY_EN
   logic parity_q, parity_d;
`endif

   assign start    = (state_q == IDLE) && par_valid;
   assign last_bit = (bit_cnt_q == BC_W'(DATA_W - 1));

   pes_bit_timer #(
      .BIT_DIV (BIT_DIV)
   ) u_bit_timer (
      .clk        (wb_clk_i),
      .rst_n      (wb_rst_n),
      .clear_i    (start),
      .en_i       (state_q != IDLE),
      .bit_tick_o (bit_tick)
   );

   // State and datapath registers; reset aborts any frame immediately.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q   <= IDLE;
         sreg_q    <= '0;
         bit_cnt_q <= '0;
`ifdef PES_PISO_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
`ifdef PES_PISO_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Next state and datapath update.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
`ifdef PES_PISO_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (par_valid) begin
               sreg_d    = par_data;
               bit_cnt_d = '0;
`ifdef PES_PISO_PARITY_EN
               parity_d  = ^par_data;
`endif
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_tick) begin
               sreg_d    = (MSB_FIRST != 0) ? {sreg_q[DATA_W-2:0], 1'b0}
                                            : {1'b0, sreg_q[DATA_W-1:1]};
               bit_cnt_d = bit_cnt_q + BC_W'(1);
               if (last_bit) begin
`ifdef PES_PISO_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = IDLE;
`endif
               end
            end
         end
`ifdef PES_PISO_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registered state only.
   always_comb begin
      par_ready = 1'b0;
      ser_out   = 1'b0;
      ser_en    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: par_ready = 1'b1;
         SHIFT: begin
            ser_en  = 1'b1;
            busy    = 1'b1;
            ser_out = (MSB_FIRST != 0) ? sreg_q[DATA_W-1] : sreg_q[0];
`ifndef PES_PISO_PARITY_EN
            done    = bit_tick && last_bit;
`endif
         end
`ifdef PES_PISO_PARITY_EN
         PARITY: begin
            ser_en  = 1'b1;
            busy    = 1'b1;
            ser_out = parity_q;
            done    = bit_tick;
         end
`endif
         default: par_ready = 1'b0;
      endcase
   end

endmodule
